// File: rtl/gbp_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gbp_pkg
// Brief   : Shared types and constants for the gshare branch history table.
// Revision: 1.0
// ============================================================================
package gbp_pkg;

    localparam int unsigned GBP_VLEN   = 64;
    localparam int unsigned GBP_HIST_W = 32;

    localparam logic [1:0] C_WEAK_NOT_TAKEN = 2'b01;
    localparam logic [1:0] C_CTR_MAX        = 2'b11;
    localparam logic [1:0] C_CTR_MIN        = 2'b00;

    typedef struct packed {
        logic                  valid;
        logic [GBP_VLEN-1:0]   pc;
        logic                  taken;
        logic                  mispredict;
        logic [GBP_HIST_W-1:0] hist;
    } gbp_update_t;

    typedef struct packed {
        logic valid;
        logic taken;
    } gbp_prediction_t;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gbp_state_e;

    function automatic logic [1:0] sat_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != C_CTR_MAX) res = ctr + 2'd1;
        end else begin
            if (ctr != C_CTR_MIN) res = ctr - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_bht_if.sv
`default_nettype none
// ============================================================================
// Module  : gshare_bht_if
// Brief   : Lookup / update / history bundle between frontend and gshare BHT.
// Revision: 1.0
// ============================================================================
interface gshare_bht_if
    import gbp_pkg::*;
#(
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned HIST_LEN        = 8,
    parameter int unsigned VLEN            = 64
);
    logic                  flush;
    logic [VLEN-1:0]       vpc;
    logic                  spec_push;
    logic                  spec_taken;
    gbp_update_t           upd;
    gbp_prediction_t       pred [INSTR_PER_FETCH];
    logic [HIST_LEN-1:0]   hist;
    logic                  ready;

    modport master (
        output flush, vpc, spec_push, spec_taken, upd,
        input  pred, hist, ready
    );

    modport slave (
        input  flush, vpc, spec_push, spec_taken, upd,
        output pred, hist, ready
    );
endinterface
`default_nettype wire

// File: rtl/gbp_ghr.sv
`default_nettype none
// ============================================================================
// Module  : gbp_ghr
// Brief   : Speculative global history register with mispredict restore.
// Revision: 1.0
// ============================================================================
module gbp_ghr #(
    parameter int unsigned HIST_LEN = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic                en_i,
    input  logic                spec_push_i,
    input  logic                spec_taken_i,
    input  logic                restore_i,
    input  logic                restore_taken_i,
    input  logic [HIST_LEN-1:0] restore_hist_i,
    output logic [HIST_LEN-1:0] hist_o
);
    logic [HIST_LEN-1:0] r_hist;
    logic [HIST_LEN-1:0] w_hist_shift;
    logic [HIST_LEN-1:0] w_hist_restore;
    logic [HIST_LEN-1:0] w_hist_next;

    generate
        if (HIST_LEN == 1) begin : g_hist_single
            logic w_unused_restore;
            assign w_unused_restore = ^restore_hist_i;
            assign w_hist_shift     = spec_taken_i;
            assign w_hist_restore   = restore_taken_i;
        end else begin : g_hist_multi
            logic w_unused_msb;
            assign w_unused_msb   = restore_hist_i[HIST_LEN-1];
            assign w_hist_shift   = {r_hist[HIST_LEN-2:0], spec_taken_i};
            // Restore rebuilds history as it should have been after the branch.
            assign w_hist_restore = {restore_hist_i[HIST_LEN-2:0], restore_taken_i};
        end
    endgenerate

    always_comb begin
        w_hist_next = r_hist;
        if (en_i) begin
            if (restore_i)        w_hist_next = w_hist_restore;
            else if (spec_push_i) w_hist_next = w_hist_shift;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) r_hist <= '0;
        else                  r_hist <= w_hist_next;
    end

    assign hist_o = r_hist;

endmodule
`default_nettype wire

// File: rtl/gshare_bht.sv
`default_nettype none
// ============================================================================
// Module  : gshare_bht
// Brief   : Gshare 2-bit counter table, combinational lookup, row-wise init.
// Revision: 1.0
// ============================================================================
module gshare_bht
    import gbp_pkg::*;
#(
    parameter int unsigned NR_ENTRIES      = 1024,
    parameter int unsigned INSTR_PER_FETCH = 2,
    parameter int unsigned HIST_LEN        = 8,
    parameter int unsigned VLEN            = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                flush_i,
    input  logic [VLEN-1:0]     vpc_i,
    input  logic                spec_push_i,
    input  logic                spec_taken_i,
    input  gbp_update_t         upd_i,
    output gbp_prediction_t     pred_o [INSTR_PER_FETCH],
    output logic [HIST_LEN-1:0] hist_o,
    output logic                ready_o
);
    localparam int unsigned ROWS   = NR_ENTRIES / INSTR_PER_FETCH;
    localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned COL_W  = (INSTR_PER_FETCH > 1) ? $clog2(INSTR_PER_FETCH) : 1;
    localparam int unsigned OFFSET = 1 + $clog2(INSTR_PER_FETCH);
    localparam logic [ROW_W-1:0] C_LAST_ROW = ROW_W'(ROWS - 1);

    gbp_state_e                 r_state;
    gbp_state_e                 w_state_next;
    logic [ROW_W-1:0]           r_init_row;
    logic [ROW_W-1:0]           w_init_row_next;

    logic [ROW_W-1:0]           w_lookup_row;
    logic [ROW_W-1:0]           w_upd_row;
    logic [COL_W-1:0]           w_upd_col;
    logic                       w_upd_fire;
    logic [1:0]                 w_upd_ctr;

    logic                       w_we;
    logic [ROW_W-1:0]           w_wr_row;
    logic [INSTR_PER_FETCH-1:0] w_wr_mask;
    logic [1:0]                 w_wr_data;

    logic [1:0]                 w_upd_col_val [INSTR_PER_FETCH];
    logic [INSTR_PER_FETCH-1:0] w_look_msb;
    logic                       w_unused_bits;

    // ---------------- init / run state machine ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_INIT;
            r_init_row <= '0;
        end else begin
            r_state    <= w_state_next;
            r_init_row <= w_init_row_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_init_row_next = r_init_row;
        if (flush_i) begin
            w_state_next    = ST_INIT;
            w_init_row_next = '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_row == C_LAST_ROW) begin
                        w_state_next    = ST_RUN;
                        w_init_row_next = '0;
                    end else begin
                        w_init_row_next = r_init_row + 1'b1;
                    end
                end
                ST_RUN:  w_state_next = ST_RUN;
                default: begin
                    w_state_next    = ST_INIT;
                    w_init_row_next = '0;
                end
            endcase
        end
    end

    assign ready_o = (r_state == ST_RUN);

    // ---------------- index computation ----------------
    assign w_lookup_row = vpc_i[OFFSET +: ROW_W] ^ ROW_W'(hist_o);
    assign w_upd_row    = upd_i.pc[OFFSET +: ROW_W] ^ ROW_W'(upd_i.hist[HIST_LEN-1:0]);

    generate
        if (INSTR_PER_FETCH > 1) begin : g_col_multi
            assign w_upd_col = upd_i.pc[1 +: COL_W];
        end else begin : g_col_single
            assign w_upd_col = '0;
        end
    endgenerate

    assign w_upd_fire = ready_o && upd_i.valid && !flush_i;
    assign w_upd_ctr  = w_upd_col_val[w_upd_col];

    // Init and training share the single table write port; init owns it in INIT.
    always_comb begin
        w_we      = 1'b0;
        w_wr_row  = '0;
        w_wr_mask = '0;
        w_wr_data = C_WEAK_NOT_TAKEN;
        if (r_state == ST_INIT) begin
            w_we      = 1'b1;
            w_wr_row  = r_init_row;
            w_wr_mask = '1;
            w_wr_data = C_WEAK_NOT_TAKEN;
        end else if (w_upd_fire) begin
            w_we      = 1'b1;
            w_wr_row  = w_upd_row;
            w_wr_mask = INSTR_PER_FETCH'(1) << w_upd_col;
            w_wr_data = sat_step(w_upd_ctr, upd_i.taken);
        end
    end

    // ---------------- counter table, one column per slot ----------------
    generate
        for (genvar c = 0; c < INSTR_PER_FETCH; c++) begin : g_col
            logic [1:0] r_ctr [ROWS];

            always_ff @(posedge clk_i) begin
                if (w_we && w_wr_mask[c]) r_ctr[w_wr_row] <= w_wr_data;
            end

            assign w_upd_col_val[c] = r_ctr[w_upd_row];
            assign w_look_msb[c]    = r_ctr[w_lookup_row][1];
            assign pred_o[c]        = {ready_o, ready_o & w_look_msb[c]};
        end
    endgenerate

    // ---------------- global history ----------------
    gbp_ghr #(
        .HIST_LEN (HIST_LEN)
    ) u_ghr (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .flush_i         (flush_i),
        .en_i            (ready_o),
        .spec_push_i     (spec_push_i),
        .spec_taken_i    (spec_taken_i),
        .restore_i       (upd_i.valid && upd_i.mispredict),
        .restore_taken_i (upd_i.taken),
        .restore_hist_i  (upd_i.hist[HIST_LEN-1:0]),
        .hist_o          (hist_o)
    );

    assign w_unused_bits = ^{vpc_i, upd_i};

endmodule
`default_nettype wire
